// File: rtl/grayscale_engine.sv
`default_nettype none
// ============================================================================
// Module   : grayscale_engine
// Brief    : Converts RGBA cache lines to luma lines through a 3-stage pipeline
//            and tracks per-job line counts. Define GRAYSCALE_ROUND_EN for
//            round-to-nearest luma instead of truncation.
// Revision : 1.0
// ============================================================================
module grayscale_engine #(
   parameter int PIXELS_PER_LINE = 16,
   parameter int W_R             = 77,
   parameter int W_G             = 150,
   parameter int W_B             = 29
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [31:0]                     num_lines,
   input  logic [32*PIXELS_PER_LINE-1:0]   line_in,
   input  logic                            line_in_valid,
   output logic [32*PIXELS_PER_LINE-1:0]   line_out,
   output logic                            line_out_valid,
   output logic [31:0]                     lines_done,
   output logic [15:0]                     overrun_cnt,
   output logic                            busy,
   output logic                            done
);

   localparam logic [15:0] c_w_r = 16'(W_R);
   localparam logic [15:0] c_w_g = 16'(W_G);
   localparam logic [15:0] c_w_b = 16'(W_B);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_num_lines;
   logic [31:0] r_accepted;
   logic        r_v1;
   logic        r_v2;
   logic        w_start_ok;
   logic        w_accept;

   assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_accept   = line_in_valid && (r_state == S_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_state_nxt = (num_lines == 32'd0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (w_accept && (r_accepted + 32'd1 == r_num_lines)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (lines_done == r_num_lines) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      busy = (r_state == S_RUN) || (r_state == S_DRAIN);
      done = (r_state == S_DONE);
   end

   // A line offered in the same cycle as an accepted start is dropped and is
   // the first overrun of the new job.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_num_lines <= 32'd0;
         r_accepted  <= 32'd0;
         lines_done  <= 32'd0;
         overrun_cnt <= 16'd0;
      end else if (w_start_ok) begin
         r_num_lines <= num_lines;
         r_accepted  <= 32'd0;
         lines_done  <= 32'd0;
         overrun_cnt <= line_in_valid ? 16'd1 : 16'd0;
      end else begin
         if (w_accept)       r_accepted <= r_accepted + 32'd1;
         if (line_out_valid) lines_done <= lines_done + 32'd1;
         if (line_in_valid && !w_accept && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v1           <= 1'b0;
         r_v2           <= 1'b0;
         line_out_valid <= 1'b0;
      end else begin
         r_v1           <= w_accept;
         r_v2           <= r_v1;
         line_out_valid <= r_v2;
      end
   end

   for (genvar i = 0; i < PIXELS_PER_LINE; i++) begin : g_pix
      logic [7:0]  w_r, w_g, w_b, w_a, w_y;
      logic [15:0] r_pr, r_pg, r_pb;
      logic [7:0]  r_a1, r_a2;
      logic [31:0] r_out;
      logic        w_unused;
`ifdef GRAYSCALE_ROUND_EN
      logic [16:0] r_sum;
      // Sum never exceeds 0xFF80 with rounding, but clamp keeps Y correct for any weights.
      assign w_y = r_sum[16] ? 8'hFF : r_sum[15:8];
`else
      logic [15:0] r_sum;
      assign w_y = r_sum[15:8];
`endif
      assign w_r      = line_in[32*i +: 8];
      assign w_g      = line_in[32*i+8 +: 8];
      assign w_b      = line_in[32*i+16 +: 8];
      assign w_a      = line_in[32*i+24 +: 8];
      assign w_unused = ^r_sum[7:0];
      assign line_out[32*i +: 32] = r_out;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_pr  <= 16'd0;
            r_pg  <= 16'd0;
            r_pb  <= 16'd0;
            r_a1  <= 8'd0;
            r_a2  <= 8'd0;
            r_sum <= '0;
            r_out <= 32'd0;
         end else begin
            if (w_accept) begin
               r_pr <= {8'd0, w_r} * c_w_r;
               r_pg <= {8'd0, w_g} * c_w_g;
               r_pb <= {8'd0, w_b} * c_w_b;
               r_a1 <= w_a;
            end
            if (r_v1) begin
`ifdef GRAYSCALE_ROUND_EN
               r_sum <= {1'b0, r_pr} + {1'b0, r_pg} + {1'b0, r_pb} + 17'd128;
`else
               r_sum <= r_pr + r_pg + r_pb;
`endif
               r_a2  <= r_a1;
            end
            if (r_v2) r_out <= {r_a2, w_y, w_y, w_y};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_grayscale_engine.sv
`default_nettype none
// Randomized self-checking bench for grayscale_engine; expected lines come from
// a per-pixel luma formula and a simple job/acceptance model.
module tb_grayscale_engine;
   localparam int PPL = 16;
   localparam int LW  = 32*PPL;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   num_lines;
   logic [LW-1:0] line_in;
   logic          line_in_valid;
   logic [LW-1:0] line_out;
   logic          line_out_valid;
   logic [31:0]   lines_done;
   logic [15:0]   overrun_cnt;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   grayscale_engine dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .num_lines      (num_lines),
      .line_in        (line_in),
      .line_in_valid  (line_in_valid),
      .line_out       (line_out),
      .line_out_valid (line_out_valid),
      .lines_done     (lines_done),
      .overrun_cnt    (overrun_cnt),
      .busy           (busy),
      .done           (done)
   );

   function automatic logic [LW-1:0] luma_line(input logic [LW-1:0] l);
      logic [LW-1:0] o;
      for (int p = 0; p < PPL; p++) begin
         int r, g, b, s, y;
         r = int'(l[32*p +: 8]);
         g = int'(l[32*p+8 +: 8]);
         b = int'(l[32*p+16 +: 8]);
         s = 77*r + 150*g + 29*b;
`ifdef GRAYSCALE_ROUND_EN
         y = (s + 128) / 256;
         if (y > 255) y = 255;
`else
         y = s / 256;
`endif
         o[32*p +: 32] = {l[32*p+24 +: 8], 8'(y), 8'(y), 8'(y)};
      end
      return o;
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int p = 0; p < PPL; p++) l[32*p +: 32] = $urandom;
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [31:0] n);
      start     = 1'b1;
      num_lines = n;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_vec++; if (line_out !== '0) begin n_err++; $display("FAIL reset_line_out got %h want 0", line_out); end
      n_vec++; if (line_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", line_out_valid); end
      n_vec++; if (lines_done !== 32'd0) begin n_err++; $display("FAIL reset_lines_done got %0d want 0", lines_done); end
      n_vec++; if (overrun_cnt !== 16'd0) begin n_err++; $display("FAIL reset_overrun got %0d want 0", overrun_cnt); end
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_idle_drop();
      line_in       = rand_line();
      line_in_valid = 1'b1;
      tick();
      line_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (line_out_valid !== 1'b0) begin n_err++; $display("FAIL idle_drop_valid got %b want 0", line_out_valid); end
      end
      n_vec++; if (overrun_cnt !== 16'd1) begin n_err++; $display("FAIL idle_drop_overrun got %0d want 1", overrun_cnt); end
   endtask

   task automatic test_pixels();
      logic [LW-1:0] lin [4];
      logic [LW-1:0] exp_l [4];
      lin[0] = {PPL{32'h000000FF}};
      lin[1] = {PPL{32'h0000FF00}};
      lin[2] = {PPL{32'h00FF0000}};
      lin[3] = {PPL{32'h80FFFFFF}};
`ifdef GRAYSCALE_ROUND_EN
      exp_l[0] = {PPL{32'h004D4D4D}};
      exp_l[2] = {PPL{32'h001D1D1D}};
`else
      exp_l[0] = {PPL{32'h004C4C4C}};
      exp_l[2] = {PPL{32'h001C1C1C}};
`endif
      exp_l[1] = {PPL{32'h00959595}};
      exp_l[3] = {PPL{32'h80FFFFFF}};
      start_job(32'd4);
      n_vec++; if (overrun_cnt !== 16'd0 || busy !== 1'b1) begin n_err++; $display("FAIL pix_start got ovr=%0d busy=%b want 0 1", overrun_cnt, busy); end
      for (int i = 0; i < 6; i++) begin
         line_in_valid = (i < 4);
         if (i < 4) line_in = lin[i];
         tick();
         if (i >= 2) begin
            n_vec++;
            if (line_out_valid !== 1'b1 || line_out !== exp_l[i-2]) begin
               n_err++; $display("FAIL pix_line%0d got v=%b %h want %h", i-2, line_out_valid, line_out, exp_l[i-2]);
            end
         end
      end
      line_in_valid = 1'b0;
      tick();
      tick();
      n_vec++; if (lines_done !== 32'd4 || done !== 1'b1) begin n_err++; $display("FAIL pix_done got ld=%0d done=%b want 4 1", lines_done, done); end
      n_vec++; if (line_out_valid !== 1'b0 || line_out !== exp_l[3]) begin n_err++; $display("FAIL pix_hold got v=%b %h want %h", line_out_valid, line_out, exp_l[3]); end
   endtask

   task automatic test_back_to_back();
      logic [LW-1:0] lin [33];
      for (int k = 0; k < 33; k++) lin[k] = rand_line();
      start_job(32'd33);
      for (int i = 0; i < 35; i++) begin
         line_in_valid = (i < 33);
         if (i < 33) line_in = lin[i];
         tick();
         if (i >= 2) begin
            n_vec++;
            if (line_out_valid !== 1'b1 || line_out !== luma_line(lin[i-2])) begin
               n_err++; $display("FAIL b2b_line%0d got v=%b %h want %h", i-2, line_out_valid, line_out, luma_line(lin[i-2]));
            end
         end else begin
            n_vec++; if (line_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early_valid got %b want 0", line_out_valid); end
         end
         n_vec++;
         if (lines_done !== 32'((i >= 2) ? i - 2 : 0)) begin
            n_err++; $display("FAIL b2b_lines_done got %0d want %0d", lines_done, (i >= 2) ? i - 2 : 0);
         end
      end
      line_in_valid = 1'b0;
      tick();
      n_vec++; if (lines_done !== 32'd33 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_drain got ld=%0d busy=%b done=%b want 33 1 0", lines_done, busy, done); end
      tick();
      n_vec++; if (done !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_done got done=%b busy=%b ovr=%0d want 1 0 0", done, busy, overrun_cnt); end
   endtask

   task automatic test_random_gaps();
      logic [LW-1:0] lin [40];
      logic          acc [40];
      int            n_acc = 0;
      int            n_drop = 0;
      start_job(32'd5);
      for (int i = 0; i < 40; i++) begin
         lin[i]        = rand_line();
         line_in       = lin[i];
         line_in_valid = ($urandom_range(0, 3) != 0) || (i >= 30 && n_acc < 5);
         acc[i]        = line_in_valid && (n_acc < 5);
         if (acc[i]) n_acc++;
         else if (line_in_valid) n_drop++;
         tick();
         if (i >= 2) begin
            n_vec++;
            if (line_out_valid !== acc[i-2] || (acc[i-2] && line_out !== luma_line(lin[i-2]))) begin
               n_err++; $display("FAIL gaps_cycle%0d got v=%b %h want v=%b %h", i, line_out_valid, line_out, acc[i-2], luma_line(lin[i-2]));
            end
         end
      end
      line_in_valid = 1'b0;
      tick();
      n_vec++; if (done !== 1'b1 || lines_done !== 32'd5) begin n_err++; $display("FAIL gaps_done got done=%b ld=%0d want 1 5", done, lines_done); end
      n_vec++; if (overrun_cnt !== 16'(n_drop)) begin n_err++; $display("FAIL gaps_overrun got %0d want %0d", overrun_cnt, n_drop); end
   endtask

   task automatic test_overrun_restart();
      logic [LW-1:0] lin [4];
      for (int k = 0; k < 4; k++) lin[k] = rand_line();
      start_job(32'd2);
      for (int i = 0; i < 6; i++) begin
         line_in_valid = (i < 4);
         if (i < 4) line_in = lin[i];
         tick();
         if (i >= 2) begin
            n_vec++;
            if (line_out_valid !== (i < 4) || (i < 4 && line_out !== luma_line(lin[i-2]))) begin
               n_err++; $display("FAIL ovr_out%0d got v=%b %h want v=%b", i-2, line_out_valid, line_out, (i < 4));
            end
         end
      end
      line_in_valid = 1'b0;
      tick();
      n_vec++; if (overrun_cnt !== 16'd2 || lines_done !== 32'd2 || done !== 1'b1) begin n_err++; $display("FAIL ovr_end got ovr=%0d ld=%0d done=%b want 2 2 1", overrun_cnt, lines_done, done); end
      start_job(32'd5);
      n_vec++; if (overrun_cnt !== 16'd0 || lines_done !== 32'd0 || busy !== 1'b1) begin n_err++; $display("FAIL restart_clear got ovr=%0d ld=%0d busy=%b want 0 0 1", overrun_cnt, lines_done, busy); end
      start_job(32'd1);
      line_in       = rand_line();
      line_in_valid = 1'b1;
      tick();
      line_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_vec++; if (busy !== 1'b1 || done !== 1'b0 || lines_done !== 32'd1) begin n_err++; $display("FAIL run_start_ignored got busy=%b done=%b ld=%0d want 1 0 1", busy, done, lines_done); end
      line_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         line_in = rand_line();
         tick();
      end
      line_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_vec++; if (done !== 1'b1 || lines_done !== 32'd5) begin n_err++; $display("FAIL restart_done got done=%b ld=%0d want 1 5", done, lines_done); end
   endtask

   task automatic test_zero_lines();
      start_job(32'd0);
      n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_done got done=%b busy=%b want 1 0", done, busy); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (line_out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid got %b want 0", line_out_valid); end
      end
      n_vec++; if (lines_done !== 32'd0) begin n_err++; $display("FAIL zero_lines_done got %0d want 0", lines_done); end
   endtask

   task automatic test_start_with_line();
      logic [LW-1:0] b;
      b             = rand_line();
      line_in       = rand_line();
      line_in_valid = 1'b1;
      start_job(32'd1);
      n_vec++; if (overrun_cnt !== 16'd1 || busy !== 1'b1) begin n_err++; $display("FAIL swl_start got ovr=%0d busy=%b want 1 1", overrun_cnt, busy); end
      line_in = b;
      tick();
      line_in_valid = 1'b0;
      tick();
      tick();
      n_vec++; if (line_out_valid !== 1'b1 || line_out !== luma_line(b)) begin n_err++; $display("FAIL swl_out got v=%b %h want %h", line_out_valid, line_out, luma_line(b)); end
      n_vec++; if (overrun_cnt !== 16'd1) begin n_err++; $display("FAIL swl_overrun got %0d want 1", overrun_cnt); end
      tick();
      tick();
   endtask

   task automatic test_reset_midflight();
      start_job(32'd4);
      line_in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         line_in = rand_line();
         tick();
      end
      line_in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_vec++; if (line_out !== '0 || line_out_valid !== 1'b0) begin n_err++; $display("FAIL rmf_out got v=%b %h want 0", line_out_valid, line_out); end
      n_vec++; if (lines_done !== 32'd0 || overrun_cnt !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rmf_status got ld=%0d ovr=%0d busy=%b done=%b want 0", lines_done, overrun_cnt, busy, done); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++; if (line_out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rmf_after got v=%b busy=%b done=%b want 0", line_out_valid, busy, done); end
      end
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      num_lines     = 32'd0;
      line_in       = '0;
      line_in_valid = 1'b0;
      tick();
      test_reset();
      test_idle_drop();
      test_pixels();
      test_back_to_back();
      test_random_gaps();
      test_overrun_restart();
      test_zero_lines();
      test_start_with_line();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
